// File: rtl/fruit_pool.sv
// Multi-slot fruit physics engine: spawns fruits from a free-slot pool, moves them
// ballistically each frame, bounces them off the side walls and reports cuts and misses.
module fruit_pool #(
  parameter int N_FRUITS       = 4,
  parameter int GRAVITY        = 1,
  parameter int VY_BASE        = 12,
  parameter int SPAWN_INTERVAL = 60,
  parameter int MIN_INTERVAL   = 16,
  parameter int X_MAX          = 629,
  parameter int Y_MAX          = 479
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic [15:0]           lfsr_in,
  input  logic                  cut_valid,
  input  logic [2:0]            cut_idx,
  output logic [10*N_FRUITS-1:0] fruit_x,
  output logic [10*N_FRUITS-1:0] fruit_y,
  output logic [N_FRUITS-1:0]   fruit_active,
  output logic                  cut_pulse,
  output logic                  miss_pulse,
  output logic                  spawn_pulse,
  output logic [7:0]            cut_count,
  output logic [7:0]            miss_count
);

  localparam int CNT_W = $clog2(SPAWN_INTERVAL + 1);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

  logic        [9:0] x_q  [N_FRUITS];
  logic        [9:0] x_d  [N_FRUITS];
  logic        [9:0] y_q  [N_FRUITS];
  logic        [9:0] y_d  [N_FRUITS];
  logic signed [3:0] vx_q [N_FRUITS];
  logic signed [3:0] vx_d [N_FRUITS];
  logic signed [7:0] vy_q [N_FRUITS];
  logic signed [7:0] vy_d [N_FRUITS];

  logic [N_FRUITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    spawn_cnt_q, spawn_cnt_d;
  logic [7:0]          cut_cnt_q, cut_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                cut_pulse_q, cut_pulse_d;
  logic                miss_pulse_q, miss_pulse_d;
  logic                spawn_pulse_q, spawn_pulse_d;

  logic signed [10:0] nx, ny;
  logic        [3:0]  miss_n;
  logic        [2:0]  level;
  logic [CNT_W-1:0]   spawn_term;
  logic               spawned;
  logic               unused_lfsr_bit;

  assign unused_lfsr_bit = lfsr_in[9];

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [2:0] level_of(input logic [7:0] cnt);
    return (cnt[7:3] > 5'd7) ? 3'd7 : cnt[5:3];
  endfunction

  // Terminal counter value: effective interval minus one, floored at MIN_INTERVAL.
  function automatic logic [CNT_W-1:0] term_of(input logic [2:0] lvl);
    int iv;
    iv = SPAWN_INTERVAL - 4 * int'(lvl);
    if (iv < MIN_INTERVAL) iv = MIN_INTERVAL;
    return CNT_W'(iv - 1);
  endfunction

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    vx_d          = vx_q;
    vy_d          = vy_q;
    active_d      = active_q;
    spawn_cnt_d   = spawn_cnt_q;
    cut_cnt_d     = cut_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    cut_pulse_d   = 1'b0;
    miss_pulse_d  = 1'b0;
    spawn_pulse_d = 1'b0;
    nx            = '0;
    ny            = '0;
    miss_n        = '0;
    spawned       = 1'b0;
    level         = level_of(cut_cnt_q);
    spawn_term    = term_of(level);

    if (enable) begin
      for (int i = 0; i < N_FRUITS; i++) begin
        if (active_q[i]) begin
          if (cut_valid && cut_idx == 3'(i)) begin
            active_d[i] = 1'b0;
            cut_pulse_d = 1'b1;
            cut_cnt_d   = sat_add8(cut_cnt_q, 4'd1);
          end else begin
            nx      = $signed({1'b0, x_q[i]}) + 11'(vx_q[i]);
            ny      = $signed({1'b0, y_q[i]}) - 11'(vy_q[i]);
            vy_d[i] = vy_q[i] - 8'(GRAVITY);
            if (nx[10] || nx > X_MAX_S) vx_d[i] = -vx_q[i];
            else                        x_d[i]  = nx[9:0];
            if (ny > Y_MAX_S) begin
              active_d[i] = 1'b0;
              miss_n      = miss_n + 4'd1;
            end else if (ny[10]) begin
              y_d[i] = '0;
            end else begin
              y_d[i] = ny[9:0];
            end
          end
        end
      end
      miss_pulse_d = |miss_n;
      miss_cnt_d   = sat_add8(miss_cnt_q, miss_n);

      // Free slots come from start-of-frame occupancy; a full pool parks the counter.
      if (spawn_cnt_q >= spawn_term) begin
        if (!(&active_q)) begin
          for (int i = 0; i < N_FRUITS; i++) begin
            if (!active_q[i] && !spawned) begin
              spawned     = 1'b1;
              x_d[i]      = 10'd64 + {1'b0, lfsr_in[8:0]};
              y_d[i]      = 10'(Y_MAX);
              vx_d[i]     = $signed({lfsr_in[12], lfsr_in[12:10]});
              vy_d[i]     = 8'(VY_BASE) + {5'b0, lfsr_in[15:13]} + {5'b0, level};
              active_d[i] = 1'b1;
            end
          end
          spawn_pulse_d = 1'b1;
          spawn_cnt_d   = '0;
        end
      end else begin
        spawn_cnt_d = spawn_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_FRUITS; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      active_q      <= '0;
      spawn_cnt_q   <= '0;
      cut_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      cut_pulse_q   <= 1'b0;
      miss_pulse_q  <= 1'b0;
      spawn_pulse_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      active_q      <= active_d;
      spawn_cnt_q   <= spawn_cnt_d;
      cut_cnt_q     <= cut_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      cut_pulse_q   <= cut_pulse_d;
      miss_pulse_q  <= miss_pulse_d;
      spawn_pulse_q <= spawn_pulse_d;
    end
  end

  for (genvar g = 0; g < N_FRUITS; g++) begin : g_out
    assign fruit_x[10*g +: 10] = x_q[g];
    assign fruit_y[10*g +: 10] = y_q[g];
  end

  assign fruit_active = active_q;
  assign cut_pulse    = cut_pulse_q;
  assign miss_pulse   = miss_pulse_q;
  assign spawn_pulse  = spawn_pulse_q;
  assign cut_count    = cut_cnt_q;
  assign miss_count   = miss_cnt_q;

endmodule
